// File: rtl/proj_pkg.sv
// Default parameters and derived-constant helpers shared by the k-mer extension block.
package proj_pkg;

    localparam int unsigned DEF_KMER_LEN      = 4;
    localparam int unsigned DEF_FRAG_LEN      = 8;
    localparam int unsigned DEF_BASE_LEN      = 4;
    localparam int unsigned DEF_MEM_LEN       = 128;
    localparam int unsigned DEF_INDICES_COUNT = 2;

    function automatic int unsigned num_bases(input int unsigned mem_len, input int unsigned base_len);
        return mem_len / base_len;
    endfunction

    function automatic int unsigned idx_w(input int unsigned mem_len, input int unsigned base_len);
        return $clog2(mem_len / base_len);
    endfunction

    // Bases taken to the left of the k-mer; the odd leftover base goes to the right.
    function automatic int unsigned ext_left(input int unsigned frag_len, input int unsigned kmer_len);
        return (frag_len - kmer_len) / 2;
    endfunction

    function automatic int unsigned max_start(input int unsigned mem_len, input int unsigned base_len,
                                              input int unsigned frag_len);
        return (mem_len / base_len) - frag_len;
    endfunction

endpackage

// File: rtl/extend_lane.sv
// One lane: clamp the fragment start around a k-mer, extract it from memory, flag overruns.
module extend_lane
    import proj_pkg::*;
#(
    parameter int unsigned KMER_LEN = DEF_KMER_LEN,
    parameter int unsigned FRAG_LEN = DEF_FRAG_LEN,
    parameter int unsigned BASE_LEN = DEF_BASE_LEN,
    parameter int unsigned MEM_LEN  = DEF_MEM_LEN,
    parameter int unsigned IDX_W    = idx_w(MEM_LEN, BASE_LEN)
) (
    input  logic [MEM_LEN-1:0]           memory,
    input  logic [IDX_W-1:0]             kmer_idx,
    output logic [FRAG_LEN*BASE_LEN-1:0] frag_c,
    output logic                         err_c
);

    localparam int unsigned NUM_BASES = num_bases(MEM_LEN, BASE_LEN);
    localparam int unsigned EXT_LEFT  = ext_left(FRAG_LEN, KMER_LEN);
    localparam int unsigned MAX_START = max_start(MEM_LEN, BASE_LEN, FRAG_LEN);
    localparam int unsigned MAX_KIDX  = NUM_BASES - KMER_LEN;
    localparam int unsigned S_W       = IDX_W + 2;
    localparam int unsigned FRAG_W    = FRAG_LEN * BASE_LEN;
    localparam int unsigned OFF_W     = $clog2(MEM_LEN);

    logic signed [S_W-1:0] raw_start;
    logic [IDX_W-1:0]      start;
    logic [OFF_W-1:0]      bit_off;

    // Signed start with room for the negative excursion near base 0.
    always_comb begin
        raw_start = $signed({2'b00, kmer_idx}) - $signed(S_W'(EXT_LEFT));
        if (raw_start < $signed(S_W'(0))) begin
            start = '0;
        end else if (raw_start > $signed(S_W'(MAX_START))) begin
            start = IDX_W'(MAX_START);
        end else begin
            start = IDX_W'(raw_start);
        end
        bit_off = OFF_W'(32'(start) * BASE_LEN);
    end

    assign frag_c = memory[bit_off +: FRAG_W];
    assign err_c  = (32'(kmer_idx) > MAX_KIDX);

endmodule

// File: rtl/extend_kmers.sv
// Parallel k-mer fragment extraction with a single registered output stage.
module extend_kmers
    import proj_pkg::*;
#(
    parameter int unsigned KMER_LEN      = DEF_KMER_LEN,
    parameter int unsigned FRAG_LEN      = DEF_FRAG_LEN,
    parameter int unsigned BASE_LEN      = DEF_BASE_LEN,
    parameter int unsigned MEM_LEN       = DEF_MEM_LEN,
    parameter int unsigned INDICES_COUNT = DEF_INDICES_COUNT,
    parameter int unsigned IDX_W         = idx_w(MEM_LEN, BASE_LEN)
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             in_valid,
    input  logic [MEM_LEN-1:0]                               memory,
    input  logic [INDICES_COUNT-1:0][IDX_W-1:0]              kmer_indices,
    output logic                                             out_valid,
    output logic [INDICES_COUNT-1:0][FRAG_LEN*BASE_LEN-1:0]  extended_kmers,
    output logic [INDICES_COUNT-1:0]                         index_err
);

    localparam int unsigned FRAG_W = FRAG_LEN * BASE_LEN;

    logic [INDICES_COUNT-1:0][FRAG_W-1:0] frag_c;
    logic [INDICES_COUNT-1:0]             err_c;

    for (genvar n = 0; n < int'(INDICES_COUNT); n++) begin : g_lane
        extend_lane #(
            .KMER_LEN (KMER_LEN),
            .FRAG_LEN (FRAG_LEN),
            .BASE_LEN (BASE_LEN),
            .MEM_LEN  (MEM_LEN),
            .IDX_W    (IDX_W)
        ) u_lane (
            .memory   (memory),
            .kmer_idx (kmer_indices[n]),
            .frag_c   (frag_c[n]),
            .err_c    (err_c[n])
        );
    end

    // Results load only on valid input; otherwise the last result is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            extended_kmers <= '0;
            index_err      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                extended_kmers <= frag_c;
                index_err      <= err_c;
            end
        end
    end

endmodule

// File: tb/tb_extend_kmers.sv
// Directed and randomized checks of extend_kmers against a base-array reference model.
module tb_extend_kmers;

    localparam int unsigned KMER_LEN  = 4;
    localparam int unsigned FRAG_LEN  = 8;
    localparam int unsigned BASE_LEN  = 4;
    localparam int unsigned MEM_LEN   = 128;
    localparam int unsigned LANES     = 2;
    localparam int unsigned IDX_W     = 5;
    localparam int          NBASES    = 32;
    localparam int          EXT_L     = 2;
    localparam int          MAX_START = 24;
    localparam int          MAX_KIDX  = 28;
    localparam logic [MEM_LEN-1:0] MEM = 128'h01234567899876543210001122334455;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic                              in_valid;
    logic [MEM_LEN-1:0]                memory;
    logic [LANES-1:0][IDX_W-1:0]       kmer_indices;
    logic                              out_valid;
    logic [LANES-1:0][FRAG_LEN*BASE_LEN-1:0] extended_kmers;
    logic [LANES-1:0]                  index_err;

    int checks   = 0;
    int failures = 0;

    logic [3:0]  bases [NBASES];
    logic [31:0] exp_frag [LANES];
    logic [LANES-1:0] exp_err;
    logic        exp_valid;

    extend_kmers #(
        .KMER_LEN      (KMER_LEN),
        .FRAG_LEN      (FRAG_LEN),
        .BASE_LEN      (BASE_LEN),
        .MEM_LEN       (MEM_LEN),
        .INDICES_COUNT (LANES),
        .IDX_W         (IDX_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .memory         (memory),
        .kmer_indices   (kmer_indices),
        .out_valid      (out_valid),
        .extended_kmers (extended_kmers),
        .index_err      (index_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_frag(input int idx);
        logic [31:0] r;
        int s;
        s = idx - EXT_L;
        if (s < 0) s = 0;
        if (s > MAX_START) s = MAX_START;
        r = '0;
        for (int j = 0; j < int'(FRAG_LEN); j++) r[j*4 +: 4] = bases[s + j];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'(exp_valid));
        check({tag, ".err"}, 64'(index_err), 64'(exp_err));
        for (int n = 0; n < int'(LANES); n++)
            check($sformatf("%s.lane%0d", tag, n), 64'(extended_kmers[n]), 64'(exp_frag[n]));
    endtask

    // Drive one cycle of stimulus, update the model, and land 1ns after the edge.
    task automatic step(input logic v, input int i0, input int i1);
        int idx [LANES];
        idx[0] = i0;
        idx[1] = i1;
        in_valid = v;
        for (int n = 0; n < int'(LANES); n++) kmer_indices[n] = IDX_W'(idx[n]);
        @(posedge clk);
        #1;
        exp_valid = v;
        if (v) begin
            for (int n = 0; n < int'(LANES); n++) begin
                exp_frag[n] = ref_frag(idx[n]);
                exp_err[n]  = (idx[n] > MAX_KIDX);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NBASES; i++) bases[i] = MEM[i*4 +: 4];
        rst_n = 1'b0;
        in_valid = 1'b0;
        memory = MEM;
        kmer_indices = '0;
        exp_valid = 1'b0;
        exp_err = '0;
        for (int n = 0; n < int'(LANES); n++) exp_frag[n] = '0;

        #1;
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 1, 15);
        check_all("low_clamp_mid");
        check("lit.lane0", 64'(extended_kmers[0]), 64'h22334455);
        check("lit.lane1", 64'(extended_kmers[1]), 64'h87654321);

        step(1'b1, 30, 28);
        check_all("high_clamp");
        check("lit.idx30", 64'(extended_kmers[0]), 64'h01234567);
        check("lit.err30_28", 64'(index_err), 64'h1);

        step(1'b1, 2, 26);
        check_all("exact_edges");
        check("lit.idx2", 64'(extended_kmers[0]), 64'h22334455);
        check("lit.idx26", 64'(extended_kmers[1]), 64'h01234567);

        step(1'b1, 7, 7);
        check_all("dup_indices");
        step(1'b1, 29, 31);
        check_all("burst2");
        step(1'b1, 0, 20);
        check_all("burst3");
        step(1'b0, 13, 4);
        check_all("hold");
        step(1'b0, 31, 31);
        check_all("hold2");

        step(1'b1, 10, 31);
        check_all("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        exp_valid = 1'b0;
        exp_err = '0;
        for (int n = 0; n < int'(LANES); n++) exp_frag[n] = '0;
        check_all("async_reset");
        #1;
        rst_n = 1'b1;
        step(1'b0, 5, 6);
        check_all("post_reset_idle");
        step(1'b1, 5, 6);
        check_all("post_reset_first");

        for (int it = 0; it < 60; it++) begin
            step(1'(($urandom % 4) != 0), int'($urandom_range(31, 0)), int'($urandom_range(31, 0)));
            check_all($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
